buf_lease_client: RTL and testbench

- Requester-side counterpart of the 16-entry buffer allocator: drives its alloc/free handshake and leases each granted buffer for a fixed hold time.
- Expired buffers are returned automatically, oldest first.
- Sits between a user request port and the allocator; nothing else drives the allocator's request inputs.

---
 rtl/buf_lease_pkg.sv | 20 ++
 rtl/buf_lease_fifo.sv | 50 +++++
 rtl/buf_lease_client.sv | 161 ++++++++++++++++
 tb/tb_buf_lease_client.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_lease_pkg.sv
// Shared types and sizing for the buffer lease client.
// Holds buffer count, address width, FSM states and the lease record.
package buf_lease_pkg;
  localparam int NBUF    = 16;
  localparam int ADDR_W  = 4;
  // Stamp storage width; the client's TS_W must not exceed it.
  localparam int STAMP_W = 8;
  localparam logic [ADDR_W:0] NBUF_CNT = (ADDR_W+1)'(NBUF);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RETRY
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  tag;
    logic [STAMP_W-1:0] stamp;
  } lease_t;
endpackage

// File: rtl/buf_lease_fifo.sv
// NBUF-deep FIFO of lease records, oldest entry readable combinationally.
// Ports: i_push/i_din write, i_pop drops head, o_head/o_full/o_empty/o_count.
module buf_lease_fifo
  import buf_lease_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_push,
  input  lease_t          i_din,
  input  logic            i_pop,
  output lease_t          o_head,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_count
);

  lease_t            r_mem [NBUF];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + ADDR_W'(1);
      if (i_pop)
        r_rptr <= r_rptr + ADDR_W'(1);
      if (i_push && !i_pop)
        r_count <= r_count + (ADDR_W+1)'(1);
      else if (i_pop && !i_push)
        r_count <= r_count - (ADDR_W+1)'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (i_push)
      r_mem[r_wptr] <= i_din;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == NBUF_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/buf_lease_client.sv
// Requester side of the buffer allocator: requests, retries, leases, frees.
// Ports: req_* user side, alloc_raw/nack/alloc_addr and free_* to allocator,
// grant_*/req_fail results, leased occupancy. BUF_LEASE_CHECK_EN adds
// shadow busy tracking, assertions and the sticky lease_err output.
module buf_lease_client
  import buf_lease_pkg::*;
#(
  parameter int HOLD      = 8,
  parameter int TS_W      = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              grant_valid,
  output logic [ADDR_W-1:0] grant_tag,
  output logic              req_fail,
  output logic              alloc_raw,
  input  logic              nack,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              free_raw,
  output logic [ADDR_W-1:0] free_addr_raw,
  output logic [ADDR_W:0]   leased
`ifdef BUF_LEASE_CHECK_EN
  ,
  output logic              lease_err
`endif
);

  localparam logic [STAMP_W-1:0] TS_MASK  = STAMP_W'((1 << TS_W) - 1);
  localparam logic [STAMP_W-1:0] HOLD_TS  = STAMP_W'(HOLD);
  localparam logic [7:0]         RETRY_LM = 8'(MAX_RETRY - 1);

  state_e            r_state;
  state_e            w_state_nx;
  logic [7:0]        r_retry;
  logic [7:0]        w_retry_nx;
  logic [TS_W-1:0]   r_ts;
  logic [ADDR_W-1:0] r_free_addr;
  logic              w_push;
  logic              w_expire;
  logic              w_full;
  logic              w_empty;
  lease_t            w_head;
  lease_t            w_din;
  logic [STAMP_W-1:0] w_age;

  assign w_din.tag   = alloc_addr;
  assign w_din.stamp = STAMP_W'(r_ts);

  buf_lease_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_expire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (leased)
  );

  // Age is taken modulo 2^TS_W so the counter may wrap freely.
  assign w_age    = (STAMP_W'(r_ts) - w_head.stamp) & TS_MASK;
  assign w_expire = !w_empty && (w_age >= HOLD_TS);

  assign free_raw      = w_expire;
  assign free_addr_raw = w_expire ? w_head.tag : r_free_addr;
  assign grant_tag     = grant_valid ? alloc_addr : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_retry     <= '0;
      r_ts        <= '0;
      r_free_addr <= '0;
    end else begin
      r_state <= w_state_nx;
      r_retry <= w_retry_nx;
      r_ts    <= r_ts + TS_W'(1);
      if (w_expire)
        r_free_addr <= w_head.tag;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_retry_nx  = r_retry;
    req_ready   = 1'b0;
    alloc_raw   = 1'b0;
    grant_valid = 1'b0;
    req_fail    = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Gated by reset so every output reads 0 while reset is held.
        req_ready = reset_n && !w_full;
        if (req_valid && req_ready) begin
          alloc_raw  = 1'b1;
          w_state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!nack) begin
          w_push      = 1'b1;
          grant_valid = 1'b1;
          w_retry_nx  = '0;
          w_state_nx  = IDLE;
        end else if (r_retry < RETRY_LM) begin
          w_retry_nx = r_retry + 8'd1;
          w_state_nx = RETRY;
        end else begin
          req_fail   = 1'b1;
          w_retry_nx = '0;
          w_state_nx = IDLE;
        end
      end
      RETRY: begin
        alloc_raw  = 1'b1;
        w_state_nx = WAIT;
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifdef BUF_LEASE_CHECK_EN
  logic [NBUF-1:0] r_shadow;
  logic            r_err;
  logic            w_dup;
  logic            w_badnack;
  logic            w_over;

  assign w_dup     = w_push && r_shadow[alloc_addr];
  assign w_badnack = (r_state == WAIT) && nack && (leased < NBUF_CNT);
  assign w_over    = (leased > NBUF_CNT);
  assign lease_err = r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_expire)
        r_shadow[w_head.tag] <= 1'b0;
      if (w_push)
        r_shadow[alloc_addr] <= 1'b1;
      r_err <= r_err || w_dup || w_badnack || w_over;
    end
  end

  always @(posedge clock) begin
    if (reset_n) begin
      assert (!w_dup) else $error("lease: duplicate grant tag");
      assert (!w_badnack) else $error("lease: nack while not full");
      assert (!w_over) else $error("lease: occupancy overflow");
    end
  end
`endif

endmodule

// File: tb/tb_buf_lease_client.sv
// Randomised bench for buf_lease_client with an allocator stub and a
// queue-based lease model checked every cycle, plus literal anchors.
module tb_buf_lease_client;
  localparam int HOLD = 40;
  localparam int TSW  = 6;
  localparam int MR   = 3;
  localparam int NB   = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       nack = 1'b0;
  logic [3:0] alloc_addr = 4'd0;
  logic       req_ready;
  logic       grant_valid;
  logic [3:0] grant_tag;
  logic       req_fail;
  logic       alloc_raw;
  logic       free_raw;
  logic [3:0] free_addr_raw;
  logic [4:0] leased;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  buf_lease_client #(
    .HOLD      (HOLD),
    .TS_W      (TSW),
    .MAX_RETRY (MR)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .grant_valid   (grant_valid),
    .grant_tag     (grant_tag),
    .req_fail      (req_fail),
    .alloc_raw     (alloc_raw),
    .nack          (nack),
    .alloc_addr    (alloc_addr),
    .free_raw      (free_raw),
    .free_addr_raw (free_addr_raw),
    .leased        (leased)
  );

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Lease model: a queue of (tag, stamp) plus the request progress.
  int mq_tag[$];
  int mq_st[$];
  int m_ts;
  int m_tries;
  int m_last;
  bit m_wait;
  bit m_retry;

  always @(negedge clock) begin
    int age;
    bit e_ready;
    bit e_alloc;
    bit e_grant;
    bit e_fail;
    bit e_free;
    int e_faddr;
    bit nk;
    if (!reset_n) begin
      mq_tag.delete();
      mq_st.delete();
      m_ts = 0;
      m_tries = 0;
      m_last = 0;
      m_wait = 0;
      m_retry = 0;
    end else begin
      e_ready = !m_wait && !m_retry && (mq_tag.size() < NB);
      e_alloc = (e_ready && req_valid) || m_retry;
      e_grant = m_wait && !nack;
      e_fail  = m_wait && nack && (m_tries + 1 >= MR);
      e_free  = 0;
      e_faddr = m_last;
      if (mq_tag.size() > 0) begin
        age = (m_ts - mq_st[0]) & ((1 << TSW) - 1);
        if (age >= HOLD) begin
          e_free = 1;
          e_faddr = mq_tag[0];
        end
      end
      chk("req_ready", req_ready, e_ready);
      chk("alloc_raw", alloc_raw, e_alloc);
      chk("grant_valid", grant_valid, e_grant);
      if (e_grant)
        chk("grant_tag", grant_tag, alloc_addr);
      chk("req_fail", req_fail, e_fail);
      chk("free_raw", free_raw, e_free);
      chk("free_addr_raw", free_addr_raw, e_faddr);
      chk("leased", leased, mq_tag.size());
      if (e_free) begin
        m_last = mq_tag.pop_front();
        void'(mq_st.pop_front());
      end
      if (e_grant) begin
        mq_tag.push_back(alloc_addr);
        mq_st.push_back(m_ts);
      end
      nk = m_wait && nack && !e_fail;
      if (nk)
        m_tries = m_tries + 1;
      else if (m_wait)
        m_tries = 0;
      m_retry = nk;
      m_wait = e_alloc;
      m_ts = (m_ts + 1) & ((1 << TSW) - 1);
    end
  end

  // Allocator stub: lowest free buffer, optional forced or random nacks.
  bit       busy [16];
  bit       pend;
  bit       rsp_nack;
  logic [3:0] rsp_addr;
  bit       force_nack;
  int       nack_pct;
  bit       s_alloc;
  bit       s_ready;
  bit       s_grant;
  bit       s_fail;
  bit       s_free;
  int       s_tag;
  int       s_faddr;
  int       s_leased;

  // Entered at posedge+1; drives the cycle, samples at negedge, returns
  // at the next posedge+1.
  task automatic step(input bit rv);
    int idx;
    req_valid = rv;
    nack = pend ? rsp_nack : 1'b0;
    alloc_addr = pend ? rsp_addr : 4'($urandom);
    @(negedge clock);
    s_alloc  = alloc_raw;
    s_ready  = req_ready;
    s_grant  = grant_valid;
    s_fail   = req_fail;
    s_free   = free_raw;
    s_tag    = grant_tag;
    s_faddr  = free_addr_raw;
    s_leased = leased;
    if (free_raw)
      busy[free_addr_raw] = 0;
    if (alloc_raw) begin
      idx = -1;
      for (int i = 15; i >= 0; i--)
        if (!busy[i]) idx = i;
      if (idx < 0 || force_nack || $urandom_range(99) < nack_pct) begin
        rsp_nack = 1;
        rsp_addr = 4'($urandom);
      end else begin
        rsp_nack = 0;
        rsp_addr = idx[3:0];
        busy[idx] = 1;
      end
    end
    pend = alloc_raw;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    req_valid = 0;
    nack = 0;
    pend = 0;
    force_nack = 0;
    foreach (busy[i]) busy[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  initial begin
    int dens;
    nack_pct = 0;
    do_reset();

    // Single request: grant tag 0 at cycle 1, free at 1+HOLD.
    step(1);
    chk("t1_alloc_c0", s_alloc, 1);
    step(0);
    chk("t1_grant_c1", s_grant, 1);
    chk("t1_tag_c1", s_tag, 0);
    step(0);
    chk("t1_leased_c2", s_leased, 1);
    repeat (37) step(0);
    step(0);
    chk("t1_nofree_c40", s_free, 0);
    step(0);
    chk("t1_free_c41", s_free, 1);
    chk("t1_faddr_c41", s_faddr, 0);
    step(0);
    chk("t1_leased_c42", s_leased, 0);

    // Continuous requests fill all 16 buffers.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      step(1);
      if (c == 7) begin
        chk("t2_grant_c7", s_grant, 1);
        chk("t2_tag_c7", s_tag, 3);
      end
      if (c == 31)
        chk("t2_tag_c31", s_tag, 15);
      if (c == 35) begin
        chk("t2_leased_full", s_leased, 16);
        chk("t2_ready_full", s_ready, 0);
        chk("t2_alloc_full", s_alloc, 0);
      end
    end
    step(1);
    chk("t2_free_c41", s_free, 1);
    chk("t2_faddr_c41", s_faddr, 0);
    step(1);
    chk("t2_ready_c42", s_ready, 1);
    chk("t2_leased_c42", s_leased, 15);

    // Persistent nack: attempts at 0,2,4, failure at 5.
    do_reset();
    force_nack = 1;
    step(1);
    chk("t3_alloc_c0", s_alloc, 1);
    step(0);
    chk("t3_alloc_c1", s_alloc, 0);
    step(0);
    chk("t3_alloc_c2", s_alloc, 1);
    step(0);
    step(0);
    chk("t3_alloc_c4", s_alloc, 1);
    step(0);
    chk("t3_fail_c5", s_fail, 1);
    chk("t3_leased_c5", s_leased, 0);
    step(0);
    chk("t3_fail_c6", s_fail, 0);
    chk("t3_ready_c6", s_ready, 1);
    force_nack = 0;

    // Stamp 60 with a 6-bit counter expires at ts 36, cycle 100.
    do_reset();
    repeat (59) step(0);
    step(1);
    step(0);
    chk("t4_grant_c60", s_grant, 1);
    repeat (38) step(0);
    step(0);
    chk("t4_nofree_c99", s_free, 0);
    step(0);
    chk("t4_free_c100", s_free, 1);

    // Async reset while a grant is pending.
    do_reset();
    step(1);
    nack = pend ? rsp_nack : 1'b0;
    alloc_addr = rsp_addr;
    req_valid = 0;
    #1;
    chk("t5_grant_prereset", grant_valid, 1);
    reset_n = 0;
    #1;
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_grant", grant_valid, 0);
    chk("t5_rst_tag", grant_tag, 0);
    chk("t5_rst_fail", req_fail, 0);
    chk("t5_rst_alloc", alloc_raw, 0);
    chk("t5_rst_free", free_raw, 0);
    chk("t5_rst_faddr", free_addr_raw, 0);
    chk("t5_rst_leased", leased, 0);
    do_reset();
    step(0);
    chk("t5_ready_after", s_ready, 1);
    chk("t5_leased_after", s_leased, 0);

    // Random traffic with random nacks, varying request density.
    do_reset();
    nack_pct = 15;
    for (int blk = 0; blk < 6; blk++) begin
      dens = (blk % 2 == 0) ? 90 : 25;
      repeat (500) step($urandom_range(99) < dens);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
